// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bundle: hazard-detect inputs from ID/EXE/MEM, memory
// request, counter clear, and the freeze/flush/status outputs.
// master = pipeline side driving requests, slave = controller.
interface pipe_hazard_ctrl_if;
   logic [3:0]  id_src1;
   logic [3:0]  id_src2;
   logic        id_use_src1;
   logic        id_two_src;
   logic [3:0]  exe_dest;
   logic        exe_wb_en;
   logic        exe_mem_read;
   logic [3:0]  mem_dest;
   logic        mem_wb_en;
   logic        exe_branch_taken;
   logic        mem_req;
   logic        cnt_clr;

   logic        pc_freeze;
   logic        ifid_freeze;
   logic        ifid_flush;
   logic        idexe_freeze;
   logic        idexe_flush;
   logic        exemem_freeze;
   logic        memwb_flush;
   logic        mem_done;
   logic [15:0] stall_cycles;

   modport master (
      output id_src1, id_src2, id_use_src1, id_two_src,
             exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, exe_branch_taken, mem_req, cnt_clr,
      input  pc_freeze, ifid_freeze, ifid_flush, idexe_freeze, idexe_flush,
             exemem_freeze, memwb_flush, mem_done, stall_cycles
   );

   modport slave (
      input  id_src1, id_src2, id_use_src1, id_two_src,
             exe_dest, exe_wb_en, exe_mem_read,
             mem_dest, mem_wb_en, exe_branch_taken, mem_req, cnt_clr,
      output pc_freeze, ifid_freeze, ifid_flush, idexe_freeze, idexe_flush,
             exemem_freeze, memwb_flush, mem_done, stall_cycles
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush controller for the five-stage pipeline.
// Detects RAW hazards between ID and EXE/MEM, squashes wrong-path work on a
// taken branch, and runs a fixed-latency data-memory wait-state FSM that
// freezes the pipeline for MEM_WAIT cycles per access.
// Optional feature macro: FORWARDING_EN (only EXE-stage load-use stalls).
// Decode outputs are combinational; only FSM state, wait_cnt and the
// saturating stall counter are registered.
module pipe_hazard_ctrl #(
   parameter int MEM_WAIT = 2
) (
   input  logic              clk,
   input  logic              rst,
   pipe_hazard_ctrl_if.slave bus
);

   localparam bit WAIT_ON   = (MEM_WAIT != 0);
   localparam int WAIT_INIT = (MEM_WAIT >= 2) ? (MEM_WAIT - 2) : 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } wait_state_t;

   wait_state_t state;
   wait_state_t next_state;
   logic [3:0]  wait_cnt;
   logic [3:0]  next_wait_cnt;
   logic        mem_stall;
   logic        mem_done_int;

   logic        src1_exe_match;
   logic        src2_exe_match;
   logic        src1_mem_match;
   logic        src2_mem_match;
   logic        hazard;

   logic        pc_freeze;
   logic        ifid_freeze;
   logic        ifid_flush;
   logic        idexe_freeze;
   logic        idexe_flush;
   logic        exemem_freeze;
   logic        memwb_flush;
   logic        mem_done;
   logic        haz_stall;
   logic        stall_inc;
   logic [15:0] stall_cycles;

   // Wait FSM state register; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
      end else begin
         state    <= next_state;
         wait_cnt <= next_wait_cnt;
      end
   end

   // Wait FSM next-state and stall/done decode.
   always_comb begin
      next_state    = state;
      next_wait_cnt = wait_cnt;
      mem_stall     = 1'b0;
      mem_done_int  = 1'b0;
      case (state)
         IDLE: begin
            if (WAIT_ON && bus.mem_req) begin
               mem_stall = 1'b1;
               if (MEM_WAIT == 1) begin
                  next_state = DONE;
               end else begin
                  next_state    = BUSY;
                  next_wait_cnt = 4'(WAIT_INIT);
               end
            end
         end
         BUSY: begin
            mem_stall = 1'b1;
            if (wait_cnt == 4'd0) begin
               next_state = DONE;
            end else begin
               next_wait_cnt = wait_cnt - 4'd1;
            end
         end
         DONE: begin
            // Pipeline advances this cycle; a request seen now belongs to
            // the access that is completing, so it is ignored.
            mem_done_int = 1'b1;
            next_state   = IDLE;
         end
         default: begin
            next_state    = IDLE;
            next_wait_cnt = 4'd0;
         end
      endcase
   end

   // Source/destination match detection against EXE and MEM.
   always_comb begin
      src1_exe_match = bus.id_use_src1 & bus.exe_wb_en & (bus.id_src1 == bus.exe_dest);
      src2_exe_match = bus.id_two_src  & bus.exe_wb_en & (bus.id_src2 == bus.exe_dest);
      src1_mem_match = bus.id_use_src1 & bus.mem_wb_en & (bus.id_src1 == bus.mem_dest);
      src2_mem_match = bus.id_two_src  & bus.mem_wb_en & (bus.id_src2 == bus.mem_dest);
`ifdef FORWARDING_EN
      // Forwarding covers everything except a load still in EXE.
      hazard = bus.exe_mem_read & (src1_exe_match | src2_exe_match);
`else
      hazard = src1_exe_match | src2_exe_match | src1_mem_match | src2_mem_match;
`endif
   end

   // Prioritised freeze/flush decode; everything is held at 0 during reset.
   always_comb begin
      pc_freeze     = 1'b0;
      ifid_freeze   = 1'b0;
      ifid_flush    = 1'b0;
      idexe_freeze  = 1'b0;
      idexe_flush   = 1'b0;
      exemem_freeze = 1'b0;
      memwb_flush   = 1'b0;
      mem_done      = 1'b0;
      haz_stall     = 1'b0;
      if (rst) begin
         mem_done = mem_done_int;
         if (mem_stall) begin
            // Branch and hazard inputs are frozen too; they get re-evaluated
            // once the access finishes.
            pc_freeze     = 1'b1;
            ifid_freeze   = 1'b1;
            idexe_freeze  = 1'b1;
            exemem_freeze = 1'b1;
            memwb_flush   = 1'b1;
         end else if (bus.exe_branch_taken) begin
            // The ID instruction is squashed, so its hazard is moot.
            ifid_flush  = 1'b1;
            idexe_flush = 1'b1;
         end else if (hazard) begin
            pc_freeze   = 1'b1;
            ifid_freeze = 1'b1;
            idexe_flush = 1'b1;
            haz_stall   = 1'b1;
         end
      end
   end

   assign stall_inc = rst & (mem_stall | haz_stall);

   // Saturating stall-cycle counter; clear wins over increment.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles <= 16'd0;
      end else if (bus.cnt_clr) begin
         stall_cycles <= 16'd0;
      end else if (stall_inc && (stall_cycles != 16'hFFFF)) begin
         stall_cycles <= stall_cycles + 16'd1;
      end
   end

   assign bus.pc_freeze     = pc_freeze;
   assign bus.ifid_freeze   = ifid_freeze;
   assign bus.ifid_flush    = ifid_flush;
   assign bus.idexe_freeze  = idexe_freeze;
   assign bus.idexe_flush   = idexe_flush;
   assign bus.exemem_freeze = exemem_freeze;
   assign bus.memwb_flush   = memwb_flush;
   assign bus.mem_done      = mem_done;
   assign bus.stall_cycles  = stall_cycles;

endmodule
